// File: rtl/bit_receiver_pkg.sv
// Shared definitions for the serial bit link (receiver and transmitter sides).
// Holds the FSM state encoding and the default field widths both ends agree on.
// No logic lives here; everything is compile-time constants and types.
package bit_receiver_pkg;

  // Default payload register width; also the largest legal payload length.
  localparam int DATA_W_DEF = 8;
  // Default width of the length field carried on the line, MSB first.
  localparam int LEN_W_DEF  = 4;

  // Receiver FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } state_t;

endpackage

// File: rtl/bit_receiver_if.sv
// Bundle of serial-side inputs and parallel-side outputs of the bit receiver.
// slave: the receiver's view (samples the line, drives results).
// master: the environment's view (drives the line, consumes results).
interface bit_receiver_if
  import bit_receiver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              serIn;
  logic              en;
  logic [DATA_W-1:0] parOut;
  logic [LEN_W-1:0]  len_out;
  logic              valid;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  serIn, en,
    output parOut, len_out, valid, frame_err, busy
  );

  modport master (
    output serIn, en,
    input  parOut, len_out, valid, frame_err, busy
  );

endinterface

// File: rtl/bit_receiver_rx_bit_counter.sv
// Loadable down-counter used to count line bits in the length and payload phases.
// Load has priority over decrement; the count stops at zero.
// cout is 1 while the count is zero, flagging the last bit of the current field.
module rx_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] parin,
  output logic         cout
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement toward zero when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = parin;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cout = (cnt_q == '0);

endmodule

// File: rtl/bit_receiver.sv
// Serial-to-parallel receiver: start bit, length field, payload, stop bit.
// Result appears one cycle after the edge that samples the deciding bit.
// No backpressure; the line is consumed only on cycles with en=1.
module bit_receiver
  import bit_receiver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  bit_receiver_if.slave  bus
);

  // The counter must hold both LEN_W-1 and L-1 (L < 2**LEN_W).
  localparam int CNT_W = LEN_W;
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(DATA_W);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] par_q, par_d;
  logic [LEN_W-1:0]  len_out_q, len_out_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  logic              cnt_load;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt_parin;
  logic              cout;
  logic [LEN_W-1:0]  len_new;

  rx_bit_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .parin (cnt_parin),
    .cout  (cout)
  );

  // Length register with the current line bit shifted in.
  assign len_new = {len_q[LEN_W-2:0], bus.serIn};

  // Next-state, datapath updates and one-cycle pulses; nothing moves without en.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sh_d      = sh_q;
    par_d     = par_q;
    len_out_d = len_out_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_parin = '0;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (!bus.serIn) begin
            state_d   = LEN;
            len_d     = '0;
            cnt_load  = 1'b1;
            cnt_parin = CNT_W'(LEN_W - 1);
          end
        end
        LEN: begin
          len_d = len_new;
          if (cout) begin
            if ((len_new != '0) && ({1'b0, len_new} <= MAX_LEN)) begin
              state_d   = DATA;
              sh_d      = '0;  // zero-extends payloads shorter than DATA_W
              cnt_load  = 1'b1;
              cnt_parin = len_new - 1'b1;
            end else begin
              state_d = IDLE;
              ferr_d  = 1'b1;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        DATA: begin
          sh_d = {sh_q[DATA_W-2:0], bus.serIn};
          if (cout) begin
            state_d = STOP;
          end else begin
            cnt_en = 1'b1;
          end
        end
        STOP: begin
          state_d = IDLE;
          if (bus.serIn) begin
            par_d     = sh_q;
            len_out_d = len_q;
            valid_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset drops any partial frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      sh_q      <= '0;
      par_q     <= '0;
      len_out_q <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      len_out_q <= len_out_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.parOut    = par_q;
  assign bus.len_out   = len_out_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bit_receiver.sv
// Directed bench for bit_receiver: good frames, bad length, bad stop,
// en gating, back-to-back frames and mid-frame reset.
module tb_bit_receiver;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   early_pulses;

  bit_receiver_if #(.DATA_W(8), .LEN_W(4)) bus ();

  bit_receiver #(.DATA_W(8), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send n bits of v, MSB first; if gap, an en=0 cycle follows every bit
  // except the last. Pulses seen before the last bit are counted.
  task automatic send_seq(input logic [31:0] v, input int n, input bit gap);
    early_pulses = 0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.serIn = v[i];
      bus.en    = 1'b1;
      tick();
      if (i != 0) begin
        if (bus.valid || bus.frame_err) early_pulses++;
        if (gap) begin
          bus.en = 1'b0;
          tick();
          if (bus.valid || bus.frame_err) early_pulses++;
        end
      end
    end
    bus.en    = 1'b0;
    bus.serIn = 1'b1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    early_pulses = 0;
    rst          = 1'b1;
    bus.en       = 1'b1;
    bus.serIn    = 1'b0;

    // 1. reset with the line toggling
    tick();
    bus.serIn = 1'b1;
    tick();
    bus.serIn = 1'b0;
    chk("rst_parOut", 32'(bus.parOut), 32'h0);
    chk("rst_len_out", 32'(bus.len_out), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst       = 1'b0;
    bus.serIn = 1'b1;
    tick();

    // 2. 0|0011|101|1
    send_seq(32'b000111011, 9, 1'b0);
    chk("t2_early", 32'(early_pulses), 32'h0);
    chk("t2_valid", 32'(bus.valid), 32'h1);
    chk("t2_ferr", 32'(bus.frame_err), 32'h0);
    chk("t2_parOut", 32'(bus.parOut), 32'h05);
    chk("t2_len_out", 32'(bus.len_out), 32'h3);
    chk("t2_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("t2_valid_clear", 32'(bus.valid), 32'h0);

    // 3. 0|1000|10110011|1 (full width)
    send_seq(32'b01000101100111, 14, 1'b0);
    chk("t3_early", 32'(early_pulses), 32'h0);
    chk("t3_valid", 32'(bus.valid), 32'h1);
    chk("t3_parOut", 32'(bus.parOut), 32'hB3);
    chk("t3_len_out", 32'(bus.len_out), 32'h8);
    tick();

    // 4a. length 0000
    send_seq(32'b00000, 5, 1'b0);
    chk("t4a_early", 32'(early_pulses), 32'h0);
    chk("t4a_ferr", 32'(bus.frame_err), 32'h1);
    chk("t4a_valid", 32'(bus.valid), 32'h0);
    chk("t4a_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("t4a_ferr_clear", 32'(bus.frame_err), 32'h0);

    // 4b. length 1001 (one past DATA_W)
    send_seq(32'b01001, 5, 1'b0);
    chk("t4b_ferr", 32'(bus.frame_err), 32'h1);
    chk("t4b_parOut", 32'(bus.parOut), 32'hB3);
    chk("t4b_len_out", 32'(bus.len_out), 32'h8);
    tick();

    // 5. 0|0010|11|0 bad stop
    send_seq(32'b00010110, 8, 1'b0);
    chk("t5_early", 32'(early_pulses), 32'h0);
    chk("t5_ferr", 32'(bus.frame_err), 32'h1);
    chk("t5_valid", 32'(bus.valid), 32'h0);
    chk("t5_parOut", 32'(bus.parOut), 32'hB3);
    chk("t5_len_out", 32'(bus.len_out), 32'h8);
    tick();

    // 6a. test 2 with en toggling every cycle
    send_seq(32'b000111011, 9, 1'b1);
    chk("t6_early", 32'(early_pulses), 32'h0);
    chk("t6_valid", 32'(bus.valid), 32'h1);
    chk("t6_parOut", 32'(bus.parOut), 32'h05);
    chk("t6_len_out", 32'(bus.len_out), 32'h3);
    tick();
    chk("t6_valid_clear", 32'(bus.valid), 32'h0);
    chk("t6_parOut_hold", 32'(bus.parOut), 32'h05);

    // Back-to-back: 0|0001|1|1 then 0|0010|10|1 with no idle bit between.
    send_seq(32'b0000111, 7, 1'b0);
    chk("b2b_1_valid", 32'(bus.valid), 32'h1);
    chk("b2b_1_parOut", 32'(bus.parOut), 32'h01);
    send_seq(32'b00010101, 8, 1'b0);
    chk("b2b_2_early", 32'(early_pulses), 32'h0);
    chk("b2b_2_valid", 32'(bus.valid), 32'h1);
    chk("b2b_2_parOut", 32'(bus.parOut), 32'h02);
    chk("b2b_2_len_out", 32'(bus.len_out), 32'h2);
    tick();

    // 6b. reset mid-DATA: 0|1000|101 then rst
    send_seq(32'b01000101, 8, 1'b0);
    chk("mid_busy", 32'(bus.busy), 32'h1);
    bus.en = 1'b1;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_parOut", 32'(bus.parOut), 32'h0);
    chk("mid_rst_len_out", 32'(bus.len_out), 32'h0);
    early_pulses = 0;
    for (int k = 0; k < 6; k++) begin
      bus.serIn = 1'b1;
      bus.en    = 1'b1;
      tick();
      if (bus.valid || bus.frame_err) early_pulses++;
    end
    chk("mid_no_pulse", 32'(early_pulses), 32'h0);
    send_seq(32'b0010010101, 10, 1'b0);
    chk("post_rst_valid", 32'(bus.valid), 32'h1);
    chk("post_rst_parOut", 32'(bus.parOut), 32'h0A);
    chk("post_rst_len_out", 32'(bus.len_out), 32'h4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
